// File: rtl/mem_bus_arbiter_if.sv
// Bundle of requester-side and Avalon-side signals for the fetch/data memory sequencer.
// master: the sequencer itself (masters the memory bus); slave: its environment.
interface mem_bus_arbiter_if;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;

  // Instruction-fetch requester
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_ack;
  logic [DATA_W-1:0] i_rdata;
  logic              i_stall;

  // Load/store requester
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [BE_W-1:0]   d_byteenable;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;
  logic              d_stall;

  // Avalon memory port
  logic [ADDR_W-1:0] address;
  logic              read;
  logic              write;
  logic [BE_W-1:0]   byteenable;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata;
  logic              waitrequest;

  modport master (
    input  i_req, i_addr,
    output i_ack, i_rdata, i_stall,
    input  d_req, d_we, d_addr, d_byteenable, d_wdata,
    output d_ack, d_rdata, d_stall,
    output address, read, write, byteenable, writedata,
    input  readdata, waitrequest
  );

  modport slave (
    output i_req, i_addr,
    input  i_ack, i_rdata, i_stall,
    output d_req, d_we, d_addr, d_byteenable, d_wdata,
    input  d_ack, d_rdata, d_stall,
    input  address, read, write, byteenable, writedata,
    output readdata, waitrequest
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Shares one Avalon memory port between the MIPS fetch and load/store requesters.
// Data normally wins arbitration; a starvation counter forces fetch through once at the limit.
module mem_bus_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                reset,
  mem_bus_arbiter_if.master   bus
);
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;
  localparam int unsigned CNT_W  = 4;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] I_ACC  = 3'd1;
  localparam logic [2:0] D_ACC  = 3'd2;
  localparam logic [2:0] I_RESP = 3'd3;
  localparam logic [2:0] D_RESP = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [CNT_W-1:0]  starve_q, starve_d;
  logic [ADDR_W-1:0] address_q, address_d;
  logic [BE_W-1:0]   byteenable_q, byteenable_d;
  logic [DATA_W-1:0] writedata_q, writedata_d;
  logic              read_q, read_d;
  logic              write_q, write_d;
  logic              we_q, we_d;

  logic arb_en;
  logic i_cand, d_cand;
  logic starve_hit;
  logic grant_i, grant_d;
  logic unused_addr_bits;

  // The requester being acknowledged this cycle is not a candidate.
  assign i_cand     = bus.i_req & (state_q != I_RESP);
  assign d_cand     = bus.d_req & (state_q != D_RESP);
  assign starve_hit = (starve_q == CNT_W'(STARVE_LIMIT));
  assign grant_d    = arb_en & d_cand & ~(i_cand & starve_hit);
  assign grant_i    = arb_en & i_cand & ~grant_d;

  // State and bus output registers; reset drops the strobes asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      starve_q     <= '0;
      address_q    <= '0;
      byteenable_q <= '0;
      writedata_q  <= '0;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      we_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_q     <= starve_d;
      address_q    <= address_d;
      byteenable_q <= byteenable_d;
      writedata_q  <= writedata_d;
      read_q       <= read_d;
      write_q      <= write_d;
      we_q         <= we_d;
    end
  end

  // Next-state, arbitration and bus output update.
  always_comb begin
    state_d      = state_q;
    starve_d     = starve_q;
    address_d    = address_q;
    byteenable_d = byteenable_q;
    writedata_d  = writedata_q;
    read_d       = read_q;
    write_d      = write_q;
    we_d         = we_q;
    arb_en       = 1'b0;

    case (state_q)
      IDLE, I_RESP, D_RESP: begin
        arb_en  = 1'b1;
        read_d  = 1'b0;
        write_d = 1'b0;
        state_d = IDLE;
      end
      I_ACC: begin
        if (!bus.waitrequest) begin
          read_d  = 1'b0;
          state_d = I_RESP;
        end
      end
      D_ACC: begin
        if (!bus.waitrequest) begin
          read_d  = 1'b0;
          write_d = 1'b0;
          state_d = D_RESP;
        end
      end
      default: begin
        read_d  = 1'b0;
        write_d = 1'b0;
        state_d = IDLE;
      end
    endcase

    if (grant_d) begin
      state_d      = D_ACC;
      address_d    = {bus.d_addr[ADDR_W-1:2], 2'b00};
      byteenable_d = bus.d_byteenable;
      writedata_d  = bus.d_wdata;
      read_d       = ~bus.d_we;
      write_d      = bus.d_we;
      we_d         = bus.d_we;
    end else if (grant_i) begin
      state_d      = I_ACC;
      address_d    = {bus.i_addr[ADDR_W-1:2], 2'b00};
      byteenable_d = {BE_W{1'b1}};
      writedata_d  = '0;
      read_d       = 1'b1;
      write_d      = 1'b0;
      we_d         = 1'b0;
    end

    // Count data wins that bypass a waiting fetch; any fetch win or idle fetch clears it.
    if (!bus.i_req || grant_i) begin
      starve_d = '0;
    end else if (grant_d && (starve_q < CNT_W'(STARVE_LIMIT))) begin
      starve_d = starve_q + CNT_W'(1);
    end
  end

  assign bus.address    = address_q;
  assign bus.read       = read_q;
  assign bus.write      = write_q;
  assign bus.byteenable = byteenable_q;
  assign bus.writedata  = writedata_q;

  // Acknowledge and read data are combinational in the response cycle.
  assign bus.i_ack   = (state_q == I_RESP);
  assign bus.d_ack   = (state_q == D_RESP);
  assign bus.i_rdata = bus.i_ack ? bus.readdata : '0;
  assign bus.d_rdata = (bus.d_ack && !we_q) ? bus.readdata : '0;
  assign bus.i_stall = bus.i_req & ~bus.i_ack;
  assign bus.d_stall = bus.d_req & ~bus.d_ack;

  assign unused_addr_bits = ^{bus.i_addr[1:0], bus.d_addr[1:0]};
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed and randomized bench for mem_bus_arbiter against a transaction-level reference model.
module tb_mem_bus_arbiter;
  localparam int unsigned STARVE_LIMIT = 4;

  typedef enum int {NONE, FETCH, DATA} who_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_bus_arbiter_if bus ();

  mem_bus_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Bench-driven stimulus
  logic        i_req_v, d_req_v, d_we_v, wait_v;
  logic [31:0] i_addr_v, d_addr_v, d_wdata_v, mem_rdata;
  logic [3:0]  d_be_v;

  assign bus.i_req        = i_req_v;
  assign bus.i_addr       = i_addr_v;
  assign bus.d_req        = d_req_v;
  assign bus.d_we         = d_we_v;
  assign bus.d_addr       = d_addr_v;
  assign bus.d_byteenable = d_be_v;
  assign bus.d_wdata      = d_wdata_v;
  assign bus.readdata     = mem_rdata;
  assign bus.waitrequest  = wait_v;

  int checks   = 0;
  int failures = 0;

  // Reference model: one outstanding bus access and one pending acknowledge.
  bit          pend;
  who_t        pend_who;
  bit          pend_we;
  logic [31:0] pend_addr, pend_wd;
  logic [3:0]  pend_be;
  who_t        ack_who;
  bit          ack_we;
  int          starve;
  bit          saw_i_ack, saw_d_ack;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    pend    = 1'b0;
    pend_who = NONE;
    ack_who = NONE;
    ack_we  = 1'b0;
    starve  = 0;
  endtask

  // One clock cycle: check outputs at negedge, advance model across the posedge.
  task automatic step();
    bit          exp_rd, exp_wr, i_c, d_c;
    who_t        win, n_ack;
    bit          n_pend, n_ack_we;
    int          n_starve;

    @(negedge clk);
    exp_rd = pend && (pend_who == FETCH || !pend_we);
    exp_wr = pend && pend_who == DATA && pend_we;
    chk("read", 32'(bus.read), 32'(exp_rd));
    chk("write", 32'(bus.write), 32'(exp_wr));
    if (pend) begin
      chk("address", bus.address, pend_addr);
      chk("byteenable", 32'(bus.byteenable), 32'(pend_be));
      chk("writedata", bus.writedata, pend_wd);
    end
    chk("i_ack", 32'(bus.i_ack), 32'(ack_who == FETCH));
    chk("d_ack", 32'(bus.d_ack), 32'(ack_who == DATA));
    if (ack_who == FETCH) chk("i_rdata", bus.i_rdata, mem_rdata);
    if (ack_who == DATA)  chk("d_rdata", bus.d_rdata, ack_we ? 32'h0 : mem_rdata);
    chk("i_stall", 32'(bus.i_stall), 32'(i_req_v && ack_who != FETCH));
    chk("d_stall", 32'(bus.d_stall), 32'(d_req_v && ack_who != DATA));
    saw_i_ack = (ack_who == FETCH);
    saw_d_ack = (ack_who == DATA);

    n_ack    = NONE;
    n_ack_we = 1'b0;
    n_pend   = pend;
    n_starve = starve;
    win      = NONE;
    if (pend) begin
      if (!wait_v) begin
        n_ack    = pend_who;
        n_ack_we = pend_we;
        n_pend   = 1'b0;
      end
      if (!i_req_v) n_starve = 0;
    end else begin
      i_c = i_req_v && ack_who != FETCH;
      d_c = d_req_v && ack_who != DATA;
      if (d_c && !(i_c && starve == int'(STARVE_LIMIT))) win = DATA;
      else if (i_c) win = FETCH;
      if (!i_req_v || win == FETCH) n_starve = 0;
      else if (win == DATA && starve < int'(STARVE_LIMIT)) n_starve = starve + 1;
    end

    @(posedge clk);
    if (!reset) begin
      model_reset();
    end else begin
      if (win == DATA) begin
        pend_who  = DATA;
        pend_we   = d_we_v;
        pend_addr = {d_addr_v[31:2], 2'b00};
        pend_be   = d_be_v;
        pend_wd   = d_wdata_v;
        n_pend    = 1'b1;
      end else if (win == FETCH) begin
        pend_who  = FETCH;
        pend_we   = 1'b0;
        pend_addr = {i_addr_v[31:2], 2'b00};
        pend_be   = 4'hF;
        pend_wd   = 32'h0;
        n_pend    = 1'b1;
      end
      pend    = n_pend;
      ack_who = n_ack;
      ack_we  = n_ack_we;
      starve  = n_starve;
    end
    #1;
  endtask

  initial begin
    reset = 1'b0;
    i_req_v = 1'b0; i_addr_v = 32'h0;
    d_req_v = 1'b0; d_we_v = 1'b0; d_addr_v = 32'h0; d_be_v = 4'h0; d_wdata_v = 32'h0;
    wait_v = 1'b0; mem_rdata = 32'h0;
    saw_i_ack = 1'b0; saw_d_ack = 1'b0;
    pend_addr = 32'h0; pend_wd = 32'h0; pend_be = 4'h0; pend_we = 1'b0;
    model_reset();

    // Reset state
    step();
    step();
    chk("rst_address", bus.address, 32'h0);
    chk("rst_byteenable", 32'(bus.byteenable), 32'h0);
    chk("rst_writedata", bus.writedata, 32'h0);
    reset = 1'b1;
    step();

    // Fetch only, minimum latency
    i_req_v = 1'b1; i_addr_v = 32'hBFC00003; wait_v = 1'b0; mem_rdata = 32'h8C220004;
    step();
    chk("t1_read", 32'(bus.read), 32'h1);
    chk("t1_address", bus.address, 32'hBFC00000);
    chk("t1_byteenable", 32'(bus.byteenable), 32'hF);
    step();
    chk("t1_i_ack", 32'(bus.i_ack), 32'h1);
    chk("t1_i_rdata", bus.i_rdata, 32'h8C220004);
    step();
    i_req_v = 1'b0;
    step();

    // Store with three wait states
    d_req_v = 1'b1; d_we_v = 1'b1; d_addr_v = 32'h00001004; d_be_v = 4'b0011;
    d_wdata_v = 32'h0000BEEF; wait_v = 1'b1;
    step();
    for (int k = 0; k < 4; k++) begin
      chk("t2_write", 32'(bus.write), 32'h1);
      chk("t2_address", bus.address, 32'h00001004);
      chk("t2_writedata", bus.writedata, 32'h0000BEEF);
      chk("t2_d_stall", 32'(bus.d_stall), 32'h1);
      if (k == 3) wait_v = 1'b0;
      step();
    end
    chk("t2_d_ack", 32'(bus.d_ack), 32'h1);
    chk("t2_d_rdata", bus.d_rdata, 32'h0);
    step();
    d_req_v = 1'b0;
    step();

    // Contention: data first, fetch granted in the data response cycle
    i_req_v = 1'b1; i_addr_v = 32'h00000400;
    d_req_v = 1'b1; d_we_v = 1'b0; d_addr_v = 32'h00003002; d_be_v = 4'hF; mem_rdata = 32'h11112222;
    step();
    chk("t3_d_read", 32'(bus.read), 32'h1);
    chk("t3_d_address", bus.address, 32'h00003000);
    chk("t3_i_stall", 32'(bus.i_stall), 32'h1);
    step();
    chk("t3_d_ack", 32'(bus.d_ack), 32'h1);
    chk("t3_d_rdata", bus.d_rdata, 32'h11112222);
    chk("t3_i_ack_low", 32'(bus.i_ack), 32'h0);
    step();
    d_req_v = 1'b0;
    chk("t3_i_read", 32'(bus.read), 32'h1);
    chk("t3_i_address", bus.address, 32'h00000400);
    step();
    chk("t3_i_ack", 32'(bus.i_ack), 32'h1);
    step();
    i_req_v = 1'b0;
    step();

    // Store then load to the same address
    d_req_v = 1'b1; d_we_v = 1'b1; d_addr_v = 32'h00002000; d_be_v = 4'hF; d_wdata_v = 32'hCAFE0001;
    mem_rdata = 32'h5A5A0F0F;
    step();
    chk("t6_write", 32'(bus.write), 32'h1);
    chk("t6_no_read", 32'(bus.read), 32'h0);
    step();
    chk("t6_store_ack", 32'(bus.d_ack), 32'h1);
    step();
    d_we_v = 1'b0;
    step();
    chk("t6_read", 32'(bus.read), 32'h1);
    chk("t6_no_write", 32'(bus.write), 32'h0);
    chk("t6_address", bus.address, 32'h00002000);
    step();
    chk("t6_load_ack", 32'(bus.d_ack), 32'h1);
    chk("t6_d_rdata", bus.d_rdata, 32'h5A5A0F0F);
    step();
    d_req_v = 1'b0;
    step();

    // Asynchronous reset in the middle of a stalled fetch
    i_req_v = 1'b1; i_addr_v = 32'h00000100; wait_v = 1'b1;
    step();
    chk("t5_read_before", 32'(bus.read), 32'h1);
    #2;
    reset = 1'b0;
    #1;
    chk("t5_read_async", 32'(bus.read), 32'h0);
    chk("t5_write_async", 32'(bus.write), 32'h0);
    chk("t5_i_ack_async", 32'(bus.i_ack), 32'h0);
    model_reset();
    i_req_v = 1'b0;
    step();
    reset = 1'b1;
    i_req_v = 1'b1; wait_v = 1'b0; mem_rdata = 32'h01234567;
    step();
    chk("t5_read_again", 32'(bus.read), 32'h1);
    chk("t5_address_again", bus.address, 32'h00000100);
    step();
    chk("t5_i_ack_again", 32'(bus.i_ack), 32'h1);
    step();
    i_req_v = 1'b0;
    step();

    // Randomized traffic: requesters re-request after their ack, slave inserts random waits
    for (int c = 0; c < 600; c++) begin
      if (!i_req_v || saw_i_ack) begin
        i_req_v  = (c >= 400) ? 1'b1 : ($urandom_range(0, 3) != 0);
        i_addr_v = $urandom;
      end
      if (!d_req_v || saw_d_ack) begin
        d_req_v   = (c >= 400) ? 1'b1 : ($urandom_range(0, 2) != 0);
        d_we_v    = 1'($urandom_range(0, 1));
        d_addr_v  = $urandom;
        d_be_v    = 4'($urandom_range(1, 15));
        d_wdata_v = $urandom;
      end
      wait_v    = ($urandom_range(0, 3) == 0);
      mem_rdata = $urandom;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
